// File: rtl/quad_velocity.sv
// Quadrature velocity estimator: signed position delta per sample window, saturated to VEL_W.
// Latency: one registered stage; the sample appears the cycle after the window-expiry cycle.
// Backpressure: none; an unacknowledged sample is overwritten and the sticky overrun flag is set.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_ni     asynchronous active-low reset
//   count_i      32-bit two's-complement position count
//   period_i     window length in clk cycles (0 = disabled)
//   clear_i      synchronous soft restart
//   ack_i        consumer acknowledge of the current sample
//   velocity_o   signed, saturated position delta over the last window
//   vel_valid_o  velocity_o holds an unacknowledged sample
//   saturated_o  velocity_o was clipped
//   overrun_o    sticky: a sample was overwritten before acknowledge
module quad_velocity #(
    parameter int VEL_W = 16,
    parameter int PER_W = 24
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [31:0]             count_i,
    input  logic [PER_W-1:0]        period_i,
    input  logic                    clear_i,
    input  logic                    ack_i,
    output logic signed [VEL_W-1:0] velocity_o,
    output logic                    vel_valid_o,
    output logic                    saturated_o,
    output logic                    overrun_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    // Clip limits kept at 32 bits so they compare directly against the raw delta.
    localparam logic signed [31:0] VMAX = (32'sd1 <<< (VEL_W - 1)) - 32'sd1;
    localparam logic signed [31:0] VMIN = -(32'sd1 <<< (VEL_W - 1));

    logic [1:0]              state_q, state_d;
    logic [PER_W-1:0]        timer_q, timer_d;
    logic [31:0]             prev_q, prev_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;

    logic signed [31:0]      delta;
    logic [PER_W-1:0]        reload;
    logic                    expire;
    logic                    period_zero;

    // Modular subtraction makes counter wrap-around come out as a small delta.
    assign delta       = $signed(count_i - prev_q);
    assign reload      = period_i - PER_W'(1);
    assign expire      = (timer_q == '0);
    assign period_zero = (period_i == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        prev_d  = prev_q;
        vel_d   = vel_q;
        valid_d = valid_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;

        if (clear_i) begin
            // Soft restart outranks expiry and acknowledge.
            state_d = period_zero ? IDLE : PRIME;
            timer_d = period_zero ? '0 : reload;
            vel_d   = '0;
            valid_d = 1'b0;
            sat_d   = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (ack_i && valid_q) begin
                valid_d = 1'b0;
            end
            if (period_zero) begin
                state_d = IDLE;
                timer_d = '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_d = PRIME;
                        timer_d = reload;
                    end
                    PRIME: begin
                        // First window only captures the reference count.
                        if (expire) begin
                            prev_d  = count_i;
                            timer_d = reload;
                            state_d = RUN;
                        end else begin
                            timer_d = timer_q - PER_W'(1);
                        end
                    end
                    RUN: begin
                        if (expire) begin
                            prev_d  = count_i;
                            timer_d = reload;
                            valid_d = 1'b1;
                            if (delta > VMAX) begin
                                vel_d = VMAX[VEL_W-1:0];
                                sat_d = 1'b1;
                            end else if (delta < VMIN) begin
                                vel_d = VMIN[VEL_W-1:0];
                                sat_d = 1'b1;
                            end else begin
                                vel_d = delta[VEL_W-1:0];
                                sat_d = 1'b0;
                            end
                            // An ack on the same edge consumes the old sample, so no overrun.
                            if (valid_q && !ack_i) begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            timer_d = timer_q - PER_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            prev_q  <= '0;
            vel_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            prev_q  <= prev_d;
            vel_q   <= vel_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign velocity_o  = vel_q;
    assign vel_valid_o = valid_q;
    assign saturated_o = sat_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_quad_velocity.sv
module tb_quad_velocity;

    logic               clk_i = 1'b0;
    logic               reset_ni;
    logic [31:0]        count_i;
    logic [23:0]        period_i;
    logic               clear_i;
    logic               ack_i;
    logic signed [15:0] velocity_o;
    logic               vel_valid_o;
    logic               saturated_o;
    logic               overrun_o;

    int n_checks = 0;
    int n_pass   = 0;

    quad_velocity #(.VEL_W(16), .PER_W(24)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .count_i     (count_i),
        .period_i    (period_i),
        .clear_i     (clear_i),
        .ack_i       (ack_i),
        .velocity_o  (velocity_o),
        .vel_valid_o (vel_valid_o),
        .saturated_o (saturated_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          p;
        logic [31:0] a;
        logic [31:0] b;
        int          vel;
        int          sat;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{4, 32'h7FFF_FFFE, 32'h8000_0001,      3, 0};
        vecs[1] = '{4, 32'h0000_0002, 32'hFFFF_FFFE,     -4, 0};
        vecs[2] = '{3, 32'h0000_0000, 32'h0000_9C40,  32767, 1};
        vecs[3] = '{3, 32'h0000_9C40, 32'h0000_0000, -32768, 1};
        vecs[4] = '{2, 32'h0000_0000, 32'h0000_7FFF,  32767, 0};
        vecs[5] = '{2, 32'h0000_0000, 32'hFFFF_8000, -32768, 0};
        vecs[6] = '{5, 32'h0000_0000, 32'hFFFF_7FFF, -32768, 1};
        vecs[7] = '{1, 32'h0000_0064, 32'h0000_005A,    -10, 0};
        vecs[8] = '{4, 32'hFFFF_FFFF, 32'h0000_0000,      1, 0};
        vecs[9] = '{6, 32'h7FFF_FFFF, 32'h8000_0000,      1, 0};

        reset_ni = 1'b1;
        count_i  = '0;
        period_i = 24'd10;
        clear_i  = 1'b0;
        ack_i    = 1'b1;

        // Reset state
        #2 reset_ni = 1'b0;
        tick();
        tick();
        chk("rst_velocity", int'(velocity_o), 0);
        chk("rst_valid", int'(vel_valid_o), 0);
        chk("rst_sat", int'(saturated_o), 0);
        chk("rst_overrun", int'(overrun_o), 0);

        // Ramp, period 10, ack held: first pulse on the 21st edge, then every 10
        reset_ni = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            tick();
            chk($sformatf("ramp_valid_e%0d", n), int'(vel_valid_o),
                (n >= 21 && (n - 21) % 10 == 0) ? 1 : 0);
            if (vel_valid_o) begin
                chk("ramp_velocity", int'(velocity_o), 10);
                chk("ramp_sat", int'(saturated_o), 0);
            end
            count_i = count_i + 32'd1;
        end

        // Table: clear, hold a for the prime window, b for the run window
        ack_i = 1'b0;
        foreach (vecs[i]) begin
            period_i = 24'(vecs[i].p);
            count_i  = vecs[i].a;
            clear_i  = 1'b1;
            tick();
            clear_i  = 1'b0;
            chk($sformatf("v%0d_clr_valid", i), int'(vel_valid_o), 0);
            repeat (vecs[i].p) tick();
            count_i = vecs[i].b;
            repeat (vecs[i].p - 1) tick();
            chk($sformatf("v%0d_early_valid", i), int'(vel_valid_o), 0);
            tick();
            chk($sformatf("v%0d_valid", i), int'(vel_valid_o), 1);
            chk($sformatf("v%0d_velocity", i), int'(velocity_o), vecs[i].vel);
            chk($sformatf("v%0d_sat", i), int'(saturated_o), vecs[i].sat);
        end

        // Overrun, ack coincident with expiry, clear
        period_i = 24'd5;
        count_i  = 32'd0;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        chk("ov_clr_velocity", int'(velocity_o), 0);
        repeat (5) tick();
        count_i = 32'd7;
        repeat (5) tick();
        chk("ov_s1_valid", int'(vel_valid_o), 1);
        chk("ov_s1_velocity", int'(velocity_o), 7);
        chk("ov_s1_overrun", int'(overrun_o), 0);
        count_i = 32'd10;
        repeat (5) tick();
        chk("ov_s2_valid", int'(vel_valid_o), 1);
        chk("ov_s2_velocity", int'(velocity_o), 3);
        chk("ov_s2_overrun", int'(overrun_o), 1);
        count_i = 32'd40010;
        repeat (4) tick();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ov_s3_valid", int'(vel_valid_o), 1);
        chk("ov_s3_velocity", int'(velocity_o), 32767);
        chk("ov_s3_sat", int'(saturated_o), 1);
        chk("ov_s3_overrun", int'(overrun_o), 1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("ov_ack_valid", int'(vel_valid_o), 0);
        chk("ov_ack_velocity", int'(velocity_o), 32767);
        chk("ov_ack_overrun", int'(overrun_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ov_clr2_valid", int'(vel_valid_o), 0);
        chk("ov_clr2_overrun", int'(overrun_o), 0);
        chk("ov_clr2_sat", int'(saturated_o), 0);
        chk("ov_clr2_velocity", int'(velocity_o), 0);

        // Mid-window asynchronous reset, disabled period, then restart at period 8
        period_i = 24'd8;
        count_i  = 32'd0;
        clear_i  = 1'b1;
        tick();
        clear_i  = 1'b0;
        repeat (8) tick();
        count_i = 32'd5;
        repeat (8) tick();
        chk("mr_pre_valid", int'(vel_valid_o), 1);
        chk("mr_pre_velocity", int'(velocity_o), 5);
        repeat (3) tick();
        reset_ni = 1'b0;
        period_i = 24'd0;
        #1;
        chk("mr_async_valid", int'(vel_valid_o), 0);
        chk("mr_async_velocity", int'(velocity_o), 0);
        tick();
        reset_ni = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick();
            chk("mr_idle_valid", int'(vel_valid_o), 0);
            count_i = count_i + 32'd3;
        end
        period_i = 24'd8;
        count_i  = 32'd0;
        for (int n = 1; n <= 17; n++) begin
            tick();
            chk($sformatf("mr_restart_valid_e%0d", n), int'(vel_valid_o), (n == 17) ? 1 : 0);
            count_i = count_i + 32'd1;
        end
        chk("mr_restart_velocity", int'(velocity_o), 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
